lsb_bit_walker: RTL and testbench
=================================

// Module: lsb_bit_walker
// PURPOSE
//  Sequential companion to the LSB-first priority encoder.
//  - Accepts a WIDTH-bit request vector over a valid/ready handshake.
//  - Emits every set bit, lowest first, one per output handshake, as a one-hot word plus a binary index.
//  - Sits downstream of request collection; feeds grant/service logic that handles one request at a time.
// PARAMETERS
//  WIDTH  default 4                  number of request bits (>=2)
//  IDXW   default $clog2(WIDTH)      width of out_idx (derived; do not override)
// PORTS
//  clk         in   1      clock; all state on the rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      in_vec is valid
//  in_ready    out  1      block can accept in_vec this cycle
//  in_vec      in   WIDTH  request vector
//  out_valid   out  1      out_onehot/out_idx/out_last are valid
//  out_ready   in   1      consumer takes the current output
//  out_onehot  out  WIDTH  lowest pending bit, one-hot
//  out_idx     out  IDXW   binary index of out_onehot
//  out_last    out  1      current output is the final pending bit
// BEHAVIOUR
//  Reset and state
//  - Reset (rst_n=0, async): state=IDLE, pending=0.
//    Outputs: in_ready=1, out_valid=0, out_onehot=0, out_idx=0, out_last=0.
//  - State machine, states IDLE and WALK:
//    - IDLE: out_valid=0, in_ready=1.
//    - Accept (in_valid&in_ready) with in_vec!=0: pending<=in_vec, go to WALK.
//    - Accept with in_vec==0: vector consumed and dropped, no output, stay in IDLE.
//    - WALK: out_valid=1. All outputs are decoded from the pending register only:
//      - out_onehot = pending & (~pending+1)
//      - out_idx = index of that bit
//      - out_last = ((pending & (pending-1))==0)
//  Handshakes
//  - Output handshake (out_valid&out_ready): pending <= pending & (pending-1).
//    If out_last=1, go to IDLE unless a new vector is accepted in the same cycle.
//  - Stall (out_valid&~out_ready): pending and all outputs hold stable. Never change an output while stalled.
//  - in_ready = (state==IDLE) | (state==WALK & out_last & out_ready), combinational.
//    - Back-to-back: the final output handshake and a new accept can share an edge.
//    - New in_vec!=0: reload pending and stay in WALK, so there is no bubble.
//    - New in_vec==0: go to IDLE.
//  - in_valid is ignored whenever in_ready=0. in_vec is sampled only on accept.
//  - Latency: accept at edge N, first output valid in the cycle after edge N.
//    Throughput is one set bit per cycle when out_ready is held at 1.
//  - Output count for a vector = popcount(in_vec). Bits are emitted in strictly ascending index order.
//  - Reset mid-WALK: pending is discarded, outputs return to their reset values immediately, nothing resumes.
//  - No X on any output when inputs are known. Do not use a combinational path from in_vec to out_*.
// TESTING (WIDTH=4)
//  1. Reset, then in_vec=4'b1011 accepted, out_ready=1:
//     -> outputs 0001/idx0/last0, 0010/idx1/last0, 1000/idx3/last1 on 3 consecutive cycles, then IDLE.
//  2. in_vec=4'b0110, out_ready=0 for 3 cycles after out_valid:
//     -> 0010/idx1 held stable, in_ready=0 throughout. On out_ready=1 -> 0100/idx2/last1.
//  3. in_vec=4'b0000 accepted -> out_valid stays 0, in_ready stays 1, the next vector is accepted normally.
//  4. in_vec=4'b1000 then 4'b0101 presented continuously, out_ready=1:
//     -> 1000/last1 handshake and 0101 accept on the same edge.
//     -> next cycles 0001, 0100/last1, with no idle cycle.
//  5. in_vec=4'b1111, rst_n asserted after the second output:
//     -> out_valid=0, in_ready=1 asynchronously. After release, no residual outputs.
//  6. in_vec=4'b1100 while in WALK on 4'b0011 (not last), in_valid=1:
//     -> in_ready=0, vector not taken until 0010/last1 handshakes.

Source files
------------

// File: rtl/lsb_bit_walker.sv
// Serialises a request vector into its set bits, lowest index first, over
// valid/ready handshakes on both sides.
module lsb_bit_walker #(
  parameter int WIDTH = 4,
  parameter int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] pending_nxt_s;
  logic [WIDTH-1:0] pending_rest_s;
  logic [WIDTH-1:0] lowest_s;
  logic             walk_s;
  logic             accept_s;
  logic             out_hs_s;

  // Output decode uses only the pending register, never in_vec.
  always_comb begin
    walk_s         = (state_r == WALK);
    lowest_s       = pending_r & (~pending_r + WIDTH'(1));
    pending_rest_s = pending_r & (pending_r - WIDTH'(1));
    out_valid      = walk_s;
    out_onehot     = walk_s ? lowest_s : {WIDTH{1'b0}};
    out_last       = walk_s && (pending_rest_s == {WIDTH{1'b0}});
    out_idx        = {IDXW{1'b0}};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (out_onehot[i]) begin
        out_idx = IDXW'(i);
      end else begin
        out_idx = out_idx;
      end
    end
    in_ready = !walk_s || (out_last && out_ready);
    accept_s = in_valid && in_ready;
    out_hs_s = out_valid && out_ready;
  end

  // Next-state: a final output handshake may share its edge with a new accept.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (in_vec != {WIDTH{1'b0}})) begin
          state_nxt_s   = WALK;
          pending_nxt_s = in_vec;
        end else begin
          state_nxt_s   = IDLE;
          pending_nxt_s = {WIDTH{1'b0}};
        end
      end
      WALK: begin
        if (out_hs_s && out_last) begin
          if (accept_s && (in_vec != {WIDTH{1'b0}})) begin
            state_nxt_s   = WALK;
            pending_nxt_s = in_vec;
          end else begin
            state_nxt_s   = IDLE;
            pending_nxt_s = {WIDTH{1'b0}};
          end
        end else if (out_hs_s) begin
          pending_nxt_s = pending_rest_s;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // State and pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pending_r <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

endmodule

// File: tb/tb_lsb_bit_walker.sv
// Self-checking bench for lsb_bit_walker: directed scenarios plus random
// traffic, checked every cycle against a queue-of-indices reference model.
module tb_lsb_bit_walker;

  localparam int WIDTH = 4;
  localparam int IDXW  = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_onehot;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;

  int n_checks;
  int n_fail;
  int exp_q[$];

  lsb_bit_walker #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_onehot(out_onehot),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Outputs expected while the model has nothing pending.
  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, " out_onehot"}, 32'(out_onehot), 32'd0);
    check_eq({tag, " out_idx"}, 32'(out_idx), 32'd0);
    check_eq({tag, " out_last"}, 32'(out_last), 32'd0);
  endtask

  // One clock: drive, check at negedge against the model, advance model at posedge.
  task automatic cycle(input string tag, input logic iv, input logic [WIDTH-1:0] vec,
                       input logic ordy);
    logic             exp_rdy;
    logic [WIDTH-1:0] oh;
    in_valid  = iv;
    in_vec    = vec;
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    if (exp_q.size() == 0) begin
      check_idle_outputs(tag);
    end else begin
      oh = WIDTH'(1) << exp_q[0];
      check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, " in_ready"}, 32'(in_ready), 32'(exp_rdy));
      check_eq({tag, " out_onehot"}, 32'(out_onehot), 32'(oh));
      check_eq({tag, " out_idx"}, 32'(out_idx), 32'(exp_q[0]));
      check_eq({tag, " out_last"}, 32'(out_last), 32'(exp_q.size() == 1));
    end
    @(posedge clk);
    if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
    if (iv && exp_rdy) begin
      for (int i = 0; i < WIDTH; i++) if (vec[i]) exp_q.push_back(i);
    end
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;
    #3;
    check_idle_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: 1011 with a ready consumer.
    cycle("s1 accept", 1'b1, 4'b1011, 1'b1);
    cycle("s1 b0", 1'b0, 4'b0000, 1'b1);
    cycle("s1 b1", 1'b0, 4'b0000, 1'b1);
    cycle("s1 b3", 1'b0, 4'b0000, 1'b1);
    cycle("s1 idle", 1'b0, 4'b0000, 1'b1);

    // Scenario 2: stall three cycles, input offered while stalled.
    cycle("s2 accept", 1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < 3; i++) cycle("s2 stall", 1'b1, 4'b1111, 1'b0);
    cycle("s2 b1", 1'b0, 4'b0000, 1'b1);
    cycle("s2 b2", 1'b0, 4'b0000, 1'b1);

    // Scenario 3: zero vector dropped, next vector taken normally.
    cycle("s3 zero", 1'b1, 4'b0000, 1'b1);
    cycle("s3 after", 1'b1, 4'b0100, 1'b1);
    cycle("s3 b2", 1'b0, 4'b0000, 1'b1);

    // Scenario 4: back-to-back 1000 then 0101.
    cycle("s4 accept", 1'b1, 4'b1000, 1'b1);
    cycle("s4 b3", 1'b1, 4'b0101, 1'b1);
    cycle("s4 b0", 1'b0, 4'b0000, 1'b1);
    cycle("s4 b2", 1'b0, 4'b0000, 1'b1);
    cycle("s4 idle", 1'b0, 4'b0000, 1'b1);

    // Scenario 6: 1100 waits behind 0011 until the last bit goes.
    cycle("s6 accept", 1'b1, 4'b0011, 1'b1);
    cycle("s6 b0", 1'b1, 4'b1100, 1'b1);
    cycle("s6 b1", 1'b1, 4'b1100, 1'b1);
    cycle("s6 b2", 1'b0, 4'b0000, 1'b1);
    cycle("s6 b3", 1'b0, 4'b0000, 1'b1);

    // Scenario 5: asynchronous reset after the second output of 1111.
    cycle("s5 accept", 1'b1, 4'b1111, 1'b1);
    cycle("s5 b0", 1'b0, 4'b0000, 1'b1);
    cycle("s5 b1", 1'b0, 4'b0000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("s5 async");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("s5 after", 1'b0, 4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    while (exp_q.size() != 0) cycle("drain", 1'b0, 4'b0000, 1'b1);
    cycle("final", 1'b0, 4'b0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
